// File: rtl/bus_interface_unit_if.sv
// CPU-side request/stall signals and memory-side valid/ready signals of the bus interface unit.
// The master modport is the bus interface unit's view. The slave modport is the CPU/memory environment's view.
`timescale 1ns/1ps

interface bus_interface_unit_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;

    logic        mem_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    logic        wbuf_empty;
    logic        bus_error;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, cpu_stall, mem_valid, mem_we, mem_addr, mem_wdata,
               wbuf_empty, bus_error
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_valid, mem_we, mem_addr, mem_wdata,
               wbuf_empty, bus_error
    );
endinterface

// File: rtl/bus_interface_unit.sv
// Posted-write buffer and valid/ready memory sequencer between the CPU datapath and external memory.
// Reads stall the CPU and drain all buffered writes first. A watchdog aborts hung transactions.
`timescale 1ns/1ps

module bus_interface_unit #(
    parameter int unsigned WBUF_DEPTH = 2,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [7:0]  ERR_DATA   = 8'hFF
) (
    input logic                  ph2,
    input logic                  resetb,
    bus_interface_unit_if.master bus
);
    localparam int unsigned PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WBUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WBUF_DEPTH - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_WAIT = 2'd1,
        READ_WAIT  = 2'd2,
        RDONE      = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]      wbuf_addr [WBUF_DEPTH];
    logic [7:0]       wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WD_W-1:0]  wd_q;

    logic wbuf_full;
    logic rd_pending;
    logic push;
    logic pop;
    logic issue_wr;
    logic issue_rd;
    logic capture;
    logic abort;
    logic wd_expired;
    logic in_wait;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Buffer full is judged on the count at the start of the cycle, so a pop in the same
    // cycle never lets a stalled write slip in early.
    assign wbuf_full  = (count_q == DEPTH_C);
    assign rd_pending = bus.cpu_req & ~bus.cpu_we;
    assign push       = bus.cpu_req & bus.cpu_we & ~wbuf_full;
    assign in_wait    = (state_q == WRITE_WAIT) || (state_q == READ_WAIT);
    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    assign bus.cpu_stall  = bus.cpu_req & (bus.cpu_we ? wbuf_full : (state_q != RDONE));
    assign bus.wbuf_empty = (count_q == '0) && (state_q != WRITE_WAIT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        pop      = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    issue_wr = 1'b1;
                    state_d  = WRITE_WAIT;
                end else if (rd_pending) begin
                    issue_rd = 1'b1;
                    state_d  = READ_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (bus.mem_ready) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    // A hung write is dropped so the buffer keeps draining.
                    pop     = 1'b1;
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                if (bus.mem_ready) begin
                    capture = 1'b1;
                    state_d = RDONE;
                end else if (wd_expired) begin
                    abort   = 1'b1;
                    state_d = RDONE;
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog counts stalled wait cycles and restarts whenever the state changes.
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            wd_q <= '0;
        end else if (in_wait && (state_d == state_q)) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    // NOTE: buffer storage is left unreset; only the pointers and count need a known value.
    always_ff @(posedge ph2) begin
        if (push) begin
            wbuf_addr[wr_ptr_q] <= bus.cpu_addr;
            wbuf_data[wr_ptr_q] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_valid <= (state_d == WRITE_WAIT) || (state_d == READ_WAIT);
            if (issue_wr) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= wbuf_addr[rd_ptr_q];
                bus.mem_wdata <= wbuf_data[rd_ptr_q];
            end else if (issue_rd) begin
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= bus.cpu_addr;
            end
        end
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            bus.cpu_rdata <= '0;
            bus.bus_error <= 1'b0;
        end else begin
            bus.bus_error <= abort;
            if (capture) begin
                bus.cpu_rdata <= bus.mem_rdata;
            end else if (abort && (state_q == READ_WAIT)) begin
                bus.cpu_rdata <= ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Scoreboard bench for bus_interface_unit: the driver queues expected memory traffic in CPU program order.
// A monitor checks each memory transaction, read retirement, bus_error and wbuf_empty against that queue.
`timescale 1ns/1ps

module tb_bus_interface_unit;
    localparam int         DEPTH       = 2;
    localparam int         TMO         = 8;
    localparam logic [7:0] ERRD        = 8'hFF;
    localparam int         STALL_LIMIT = 200;
    localparam int         HANG        = 1000000;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic ph2    = 1'b0;
    logic resetb = 1'b0;

    bus_interface_unit_if bus ();

    bus_interface_unit #(
        .WBUF_DEPTH (DEPTH),
        .TIMEOUT    (TMO),
        .ERR_DATA   (ERRD)
    ) dut (
        .ph2    (ph2),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 ph2 = ~ph2;

    int   n_checks = 0;
    int   n_pass   = 0;
    txn_t txn_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] ext_mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];
    int   resp_wait      = -1;
    int   last_valid_len = -1;
    int   outstanding    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic bail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ext_rd(input logic [15:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // External memory: waits resp_wait cycles (or a random count, sometimes forever) before ready.
    initial begin
        int   r_cnt;
        int   r_w;
        logic r_active;
        r_active      = 1'b0;
        r_cnt         = 0;
        r_w           = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(posedge ph2);
            #1;
            if (bus.mem_valid) begin
                if (!r_active) begin
                    r_active = 1'b1;
                    r_cnt    = 0;
                    if (resp_wait >= 0) r_w = resp_wait;
                    else r_w = ($urandom_range(0, 11) == 0) ? HANG : int'($urandom_range(0, 4));
                end else begin
                    r_cnt++;
                end
                bus.mem_ready = (r_cnt == r_w);
            end else begin
                r_active      = 1'b0;
                bus.mem_ready = 1'b0;
            end
            if (bus.mem_ready && bus.mem_we) ext_mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = (bus.mem_ready && !bus.mem_we) ? ext_rd(bus.mem_addr) : 8'($urandom);
        end
    end

    task automatic finish_txn(input logic ok);
        txn_t t;
        if (txn_q.size() == 0) return;
        t = txn_q.pop_front();
        if (t.we) begin
            outstanding--;
            if (ok) ref_mem[t.addr] = t.data;
        end else begin
            rd_q.push_back(ok ? ref_rd(t.addr) : ERRD);
        end
    endtask

    // Monitor: everything is sampled on the falling edge, away from the active edge.
    initial begin
        logic prev_valid;
        logic prev_hs;
        logic hs;
        logic aborted;
        int   dur;
        txn_t cur;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        dur        = 0;
        cur        = '0;
        forever begin
            @(negedge ph2);
            if (!resetb) begin
                txn_q.delete();
                rd_q.delete();
                outstanding = 0;
                prev_valid  = 1'b0;
                prev_hs     = 1'b0;
                dur         = 0;
                continue;
            end
            hs      = bus.mem_valid & bus.mem_ready;
            aborted = prev_valid & ~bus.mem_valid & ~prev_hs;
            if (aborted) begin
                check("abort_wait_cycles", dur, TMO);
                finish_txn(1'b0);
            end
            check("bus_error", bus.bus_error, aborted);
            check("wbuf_empty", bus.wbuf_empty, outstanding == 0);
            if (bus.mem_valid && !prev_valid) begin
                dur = 0;
                if (txn_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL txn_order: got unexpected mem txn addr %0h expected none", bus.mem_addr);
                    cur = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                end else begin
                    cur = txn_q[0];
                end
            end
            if (bus.mem_valid) begin
                dur++;
                check("mem_txn", {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00},
                                 {cur.we, cur.addr, cur.we ? cur.data : 8'h00});
            end
            if (hs) begin
                last_valid_len = dur;
                finish_txn(1'b1);
            end
            if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_retire: got read retire with data %0h expected no retire", bus.cpu_rdata);
                end else begin
                    check("cpu_rdata", bus.cpu_rdata, rd_q.pop_front());
                end
            end
            if (bus.cpu_req && bus.cpu_we && !bus.cpu_stall) outstanding++;
            prev_valid = bus.mem_valid;
            prev_hs    = hs;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge ph2);
            #1;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                              output int stalls, output logic [7:0] rd);
        txn_t t;
        t = {we, a, d};
        txn_q.push_back(t);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        stalls        = 0;
        forever begin
            @(negedge ph2);
            if (!bus.cpu_stall) break;
            stalls++;
            if (stalls > STALL_LIMIT) bail("cpu_stall_bound");
        end
        rd = bus.cpu_rdata;
        @(posedge ph2);
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge ph2);
            if (bus.wbuf_empty && txn_q.size() == 0 && !bus.mem_valid) break;
            n++;
            if (n > 500) bail("drain_bound");
        end
        @(posedge ph2);
        #1;
    endtask

    initial begin
        int         s1, s2, s3;
        logic [7:0] rd;
        int         vcount;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;

        // Reset state
        #12;
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_cpu_stall", bus.cpu_stall, 1'b0);
        check("rst_wbuf_empty", bus.wbuf_empty, 1'b1);
        check("rst_bus_error", bus.bus_error, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
        check("rst_mem_addr", {bus.mem_we, bus.mem_addr}, 17'h0);
        @(negedge ph2);
        #2;
        resetb = 1'b1;
        cycles(2);

        // Single posted write, immediate ready
        resp_wait      = 0;
        last_valid_len = -1;
        cpu_access(1'b1, 16'h0200, 8'h5A, s1, rd);
        check("wr1_stall", s1, 0);
        drain();
        check("wr1_valid_len", last_valid_len, 1);
        check("wr1_wbuf_empty", bus.wbuf_empty, 1'b1);

        // Three back-to-back writes into a two-entry buffer, five wait states each
        resp_wait = 5;
        cpu_access(1'b1, 16'h0101, 8'h11, s1, rd);
        cpu_access(1'b1, 16'h0102, 8'h22, s2, rd);
        cpu_access(1'b1, 16'h0103, 8'h33, s3, rd);
        check("wr3_stall_a", s1, 0);
        check("wr3_stall_b", s2, 0);
        check("wr3_stall_c", s3, 6);
        drain();

        // Write then read of the same address: read waits for the write to drain
        resp_wait = 0;
        cpu_access(1'b1, 16'h0010, 8'h33, s1, rd);
        cpu_access(1'b0, 16'h0010, 8'h00, s2, rd);
        check("raw_wr_stall", s1, 0);
        check("raw_rd_stall", s2, 4);
        check("raw_rd_data", rd, 8'h33);
        drain();

        // Read with three wait states
        ext_mem[16'h0300] = 8'hC4;
        ref_mem[16'h0300] = 8'hC4;
        resp_wait = 3;
        cpu_access(1'b0, 16'h0300, 8'h00, s1, rd);
        check("rd3_stall", s1, 5);
        check("rd3_data", rd, 8'hC4);
        drain();

        // Hung read: watchdog returns error data
        resp_wait = HANG;
        cpu_access(1'b0, 16'h0500, 8'h00, s1, rd);
        check("tmo_rd_stall", s1, TMO + 1);
        check("tmo_rd_data", rd, ERRD);
        drain();

        // Asynchronous reset while a write is in flight with two entries buffered
        resp_wait = HANG;
        cpu_access(1'b1, 16'h0A00, 8'hE1, s1, rd);
        cpu_access(1'b1, 16'h0A01, 8'hE2, s2, rd);
        cycles(2);
        check("pre_rst_valid", bus.mem_valid, 1'b1);
        @(negedge ph2);
        #2;
        resetb = 1'b0;
        #1;
        check("mid_rst_valid", bus.mem_valid, 1'b0);
        check("mid_rst_wbuf_empty", bus.wbuf_empty, 1'b1);
        cycles(2);
        @(negedge ph2);
        #2;
        resetb    = 1'b1;
        resp_wait = 0;
        vcount    = 0;
        repeat (20) begin
            @(negedge ph2);
            if (bus.mem_valid) vcount++;
        end
        check("post_rst_no_stale", vcount, 0);
        @(posedge ph2);
        #1;

        // Randomized traffic against the scoreboard
        resp_wait = -1;
        for (int i = 0; i < 400; i++) begin
            logic        we;
            logic [15:0] a;
            logic [7:0]  d;
            we = 1'($urandom_range(0, 1));
            a  = 16'h4000 + 16'($urandom_range(0, 15));
            d  = 8'($urandom);
            cpu_access(we, a, d, s1, rd);
            if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 3)));
        end
        drain();
        check("final_txn_q", txn_q.size(), 0);
        check("final_rd_q", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
Sits directly downstream of the CPU datapath. Takes the datapath's address bus, its write data and the read/write strobes from the controller, and runs a valid/ready handshake to external memory. Writes are posted into a small write buffer and do not stall the CPU. Reads stall the CPU until data returns and are ordered behind all buffered writes. A watchdog aborts hung transactions and flags a bus error.

Parameters:
WBUF_DEPTH, 2, number of posted-write entries (power of two, 1..8)
TIMEOUT, 64, wait cycles before abort; 0 disables the watchdog
ERR_DATA, 8'hFF, read data returned on an aborted read

Ports:
ph2  input  1  single clock; all state updates on rising edge
resetb  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request; held stable while cpu_stall=1
cpu_we  input  1  1=write, 0=read
cpu_addr  input  16  datapath address bus
cpu_wdata  input  8  datapath data_out
cpu_rdata  output  8  registered read data, valid in the cycle a read retires
cpu_stall  output  1  combinational; request cannot retire this cycle
mem_valid  output  1  registered; memory transaction active
mem_we  output  1  registered; transaction is a write
mem_addr  output  16  registered transaction address
mem_wdata  output  8  registered transaction write data
mem_ready  input  1  memory completes transaction this cycle
mem_rdata  input  8  read data, sampled when mem_valid & mem_ready & ~mem_we
wbuf_empty  output  1  write buffer empty and no write in flight (fence)
bus_error  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset is asynchronous. All outputs go to 0 except wbuf_empty=1. State goes to IDLE, buffer count to 0, watchdog to 0. Buffer contents and any in-flight transaction are discarded. mem_valid drops immediately.
- States: IDLE, WRITE_WAIT, READ_WAIT, RDONE.
- Write accept: cpu_req & cpu_we & (count < WBUF_DEPTH), sampled at start of cycle. The entry is pushed at the edge, cpu_stall=0, and the write retires the same cycle.
  - Buffer full (count==WBUF_DEPTH): cpu_stall=1, even if a pop happens that cycle. The push occurs in the first cycle that starts with count < DEPTH.
- Read: cpu_stall=1 for every cycle of cpu_req & ~cpu_we except the RDONE cycle.
- IDLE, priority order:
  - (1) buffer non-empty: load head into mem_addr/mem_wdata, mem_we=1, mem_valid=1, go to WRITE_WAIT.
  - (2) else a read is pending: load cpu_addr, mem_we=0, mem_valid=1, go to READ_WAIT.
  - (3) else remain in IDLE.
- Reads are never issued while buffered writes remain; there is no forwarding from the buffer.
- WRITE_WAIT: on mem_ready, pop the head, drop mem_valid, return to IDLE. There is at least one IDLE cycle between transactions.
- READ_WAIT: on mem_ready, cpu_rdata <= mem_rdata, drop mem_valid, go to RDONE.
- RDONE: cpu_stall=0, the read retires, return to IDLE. cpu_rdata holds its value until the next read completes.
- Minimum read: request seen at edge n; mem_valid high after edge n+1; data captured at edge n+2 if ready is immediate; retires in the cycle after edge n+2. That gives 2 stall cycles.
- Watchdog: counts cycles in WRITE_WAIT/READ_WAIT with mem_ready=0 and clears on state entry. When it reaches TIMEOUT:
  - mem_valid drops, bus_error pulses for 1 cycle.
  - A write entry is popped (discarded) and the FSM returns to IDLE.
  - A read loads cpu_rdata=ERR_DATA and goes to RDONE.
- Pointers wrap modulo WBUF_DEPTH. count ranges 0..WBUF_DEPTH and is updated by push/pop in the same edge (net ±1 or 0).
- wbuf_empty = (count==0) & ~(state==WRITE_WAIT).
- mem_addr/mem_wdata/mem_we hold their value while mem_valid=1 and are don't-care otherwise.

Test Plan:
- Reset, then single write A=16'h0200, D=8'h5A, mem_ready tied 1 -> no stall. mem_valid/mem_we high with addr 0200 / data 5A for 1 cycle. wbuf_empty=1 after.
- Three back-to-back writes, DEPTH=2, mem_ready=0 for 5 cycles -> writes 1–2 retire immediately. Write 3 stalls until the first pop, then retires. Memory sees the writes in order.
- Write 16'h0010<=8'h33 then read 16'h0010, mem_ready=1 -> the read's mem_valid follows completion of the write. cpu_rdata=mem_rdata. Stall count is 2 plus the drain cycles.
- Read with 3 wait states, mem_rdata=8'hC4 -> cpu_stall high for 5 cycles. cpu_rdata=C4 in the retire cycle.
- TIMEOUT=4, read with mem_ready stuck 0 -> bus_error pulse after 4 wait cycles. cpu_rdata=8'hFF, then the read retires.
- resetb low mid-WRITE_WAIT with 2 entries buffered -> mem_valid=0 immediately, wbuf_empty=1. After release, no stale writes are issued.
